// File: rtl/l2_xbar_pkg.sv
// Shared types and helpers for the L2 crossbar request path.
package l2_xbar_pkg;

    // Default crossbar widths
    localparam int unsigned L2_N_CH       = 4;
    localparam int unsigned L2_ADDR_WIDTH = 32;
    localparam int unsigned L2_ID_WIDTH   = 16;
    localparam int unsigned L2_DATA_WIDTH = 64;
    localparam int unsigned L2_BE_WIDTH   = L2_DATA_WIDTH / 8;
    localparam int unsigned L2_TAG_WIDTH  = L2_DATA_WIDTH / 8;

    // Width of a round-robin channel index; at least one bit
    function automatic int unsigned rr_idx_w(input int unsigned n_ch);
        return (n_ch > 32'd1) ? $clog2(n_ch) : 32'd1;
    endfunction

    typedef logic [rr_idx_w(L2_N_CH)-1:0] rr_idx_t;

    // One request channel payload at default widths; the fan-in builds an
    // identically ordered struct sized from its own parameters.
    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0] addr;
        logic [L2_DATA_WIDTH-1:0] wdata;
        logic [L2_TAG_WIDTH-1:0]  wtag;
        logic                     wen;
        logic [L2_BE_WIDTH-1:0]   be;
        logic [L2_ID_WIDTH-1:0]   id;
    } l2_req_t;

endpackage

// File: rtl/rr_prio_select_l2.sv
// Round-robin priority select: first requester at or after the pointer,
// wrapping at N_CH (which need not be a power of two).
module rr_prio_select_l2
    import l2_xbar_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = rr_idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [N_CH-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned sum_s;
    int unsigned ch_s;
    logic        hit_s;

    // Scan channels from rr_i upward with wrap; the first hit is the winner
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum_s    = 32'd0;
        ch_s     = 32'd0;
        hit_s    = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            sum_s        = 32'(rr_i) + 32'(k);
            ch_s         = (sum_s >= N_CH) ? (sum_s - N_CH) : sum_s;
            hit_s        = req_i[ch_s] & ~any_o;
            onehot_o[ch_s] = hit_s;
            idx_o        = hit_s ? IDX_W'(ch_s) : idx_o;
            any_o        = any_o | hit_s;
        end
    end

endmodule

// File: rtl/fanin_req_l2_rr.sv
// N-channel round-robin request fan-in onto one L2 bank port, with an
// optional single-entry output slice cutting the bank-grant path.
module fanin_req_l2_rr
    import l2_xbar_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TAG_WIDTH  = DATA_WIDTH / 8,
    parameter bit          OUT_REG    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            data_req_i,
    input  logic [N_CH*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_CH*TAG_WIDTH-1:0]  data_wtag_i,
    input  logic [N_CH*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_CH-1:0]            data_wen_i,
    input  logic [N_CH*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_CH*ID_WIDTH-1:0]   data_ID_i,
    output logic [N_CH-1:0]            data_gnt_o,
    output logic                       data_req_o,
    output logic [DATA_WIDTH-1:0]      data_wdata_o,
    output logic [TAG_WIDTH-1:0]       data_wtag_o,
    output logic [ADDR_WIDTH-1:0]      data_add_o,
    output logic                       data_wen_o,
    output logic [BE_WIDTH-1:0]        data_be_o,
    output logic [ID_WIDTH-1:0]        data_ID_o,
    input  logic                       data_gnt_i
);

    localparam int unsigned IDX_W = rr_idx_w(N_CH);

    // Same field order as l2_req_t, sized by this instance's parameters
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TAG_WIDTH-1:0]  wtag;
        logic                  wen;
        logic [BE_WIDTH-1:0]   be;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    req_t             req_arr_s [N_CH];
    req_t             sel_req_s;
    req_t             out_req_s;
    logic [N_CH-1:0]  win_oh_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             any_req_s;
    logic             accept_s;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_unpack
        assign req_arr_s[ch] = '{
            addr:  data_add_i[ch*ADDR_WIDTH +: ADDR_WIDTH],
            wdata: data_wdata_i[ch*DATA_WIDTH +: DATA_WIDTH],
            wtag:  data_wtag_i[ch*TAG_WIDTH +: TAG_WIDTH],
            wen:   data_wen_i[ch],
            be:    data_be_i[ch*BE_WIDTH +: BE_WIDTH],
            id:    data_ID_i[ch*ID_WIDTH +: ID_WIDTH]
        };
    end

    rr_prio_select_l2 #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_sel (
        .req_i    (data_req_i),
        .rr_i     (rr_q),
        .onehot_o (win_oh_s),
        .idx_o    (win_idx_s),
        .any_o    (any_req_s)
    );

    // With no requester the mux parks on the pointer channel
    assign sel_idx_s = any_req_s ? win_idx_s : rr_q;
    assign sel_req_s = req_arr_s[sel_idx_s];

    // Pointer advances past the accepted winner, wrapping to 0 after N_CH-1
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            rr_d = (win_idx_s == IDX_W'(N_CH - 1)) ? IDX_W'(0) : (win_idx_s + IDX_W'(1));
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    if (OUT_REG) begin : g_slice
        req_t slice_q;
        req_t slice_d;
        logic v_q;
        logic v_d;
        logic ld_s;

        // Load whenever someone requests and the slice is empty or draining
        assign ld_s       = any_req_s & (~v_q | data_gnt_i);
        assign accept_s   = ld_s;
        assign data_gnt_o = win_oh_s & {N_CH{ld_s}};
        assign data_req_o = v_q;
        assign out_req_s  = slice_q;

        // Next slice state: load replaces, lone drain empties, otherwise hold
        always_comb begin
            slice_d = slice_q;
            v_d     = v_q;
            if (ld_s) begin
                slice_d = sel_req_s;
                v_d     = 1'b1;
            end else if (data_gnt_i) begin
                v_d     = 1'b0;
            end else begin
                v_d     = v_q;
            end
        end

        // Slice entry and valid flag; reset discards any pending entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slice_q <= '0;
                v_q     <= 1'b0;
            end else begin
                slice_q <= slice_d;
                v_q     <= v_d;
            end
        end
    end else begin : g_comb
        assign accept_s   = any_req_s & data_gnt_i;
        assign data_gnt_o = win_oh_s & {N_CH{data_gnt_i}};
        assign data_req_o = any_req_s;
        assign out_req_s  = sel_req_s;
    end

    assign data_add_o   = out_req_s.addr;
    assign data_wdata_o = out_req_s.wdata;
    assign data_wtag_o  = out_req_s.wtag;
    assign data_wen_o   = out_req_s.wen;
    assign data_be_o    = out_req_s.be;
    assign data_ID_o    = out_req_s.id;

endmodule

// File: tb/tb_fanin_req_l2_rr.sv
// Directed bench for fanin_req_l2_rr: registered 4-channel, registered
// 3-channel and combinational 4-channel instances on one clock.
module tb_fanin_req_l2_rr;

    localparam int AW = 32;
    localparam int IW = 16;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Shared per-channel payload (channel c values derived from c)
    logic [4*DW-1:0] wdata_v;
    logic [4*TW-1:0] wtag_v;
    logic [4*AW-1:0] add_v;
    logic [3:0]      wen_v;
    logic [4*BW-1:0] be_v;
    logic [4*IW-1:0] id_v;

    function automatic logic [AW-1:0] exp_addr(input int c);
        return 32'h1000_0000 + 32'(c) * 32'h100;
    endfunction
    function automatic logic [IW-1:0] exp_id(input int c);
        return 16'h0028 + 16'(c);
    endfunction
    function automatic logic [DW-1:0] exp_wdata(input int c);
        return {32'hD00D_0000 + 32'(c), 32'hCAFE_0000 + 32'(c)};
    endfunction
    function automatic logic [TW-1:0] exp_wtag(input int c);
        return 8'h50 + 8'(c);
    endfunction
    function automatic logic [BW-1:0] exp_be(input int c);
        return 8'hF0 ^ 8'(c);
    endfunction

    // DUT A: 4 channels, registered slice
    logic [3:0]    req4, gnt4_o;
    logic          gnt4, req4_o, wen4_o;
    logic [DW-1:0] wdata4_o;
    logic [TW-1:0] wtag4_o;
    logic [AW-1:0] add4_o;
    logic [BW-1:0] be4_o;
    logic [IW-1:0] id4_o;

    fanin_req_l2_rr #(.N_CH(4), .OUT_REG(1'b1)) dut4 (
        .clk(clk), .rst(rst),
        .data_req_i(req4), .data_wdata_i(wdata_v), .data_wtag_i(wtag_v),
        .data_add_i(add_v), .data_wen_i(wen_v), .data_be_i(be_v), .data_ID_i(id_v),
        .data_gnt_o(gnt4_o), .data_req_o(req4_o), .data_wdata_o(wdata4_o),
        .data_wtag_o(wtag4_o), .data_add_o(add4_o), .data_wen_o(wen4_o),
        .data_be_o(be4_o), .data_ID_o(id4_o), .data_gnt_i(gnt4)
    );

    // DUT B: 3 channels, registered slice
    logic [2:0]    req3, gnt3_o;
    logic          gnt3, req3_o, wen3_o;
    logic [DW-1:0] wdata3_o;
    logic [TW-1:0] wtag3_o;
    logic [AW-1:0] add3_o;
    logic [BW-1:0] be3_o;
    logic [IW-1:0] id3_o;

    fanin_req_l2_rr #(.N_CH(3), .OUT_REG(1'b1)) dut3 (
        .clk(clk), .rst(rst),
        .data_req_i(req3), .data_wdata_i(wdata_v[3*DW-1:0]), .data_wtag_i(wtag_v[3*TW-1:0]),
        .data_add_i(add_v[3*AW-1:0]), .data_wen_i(wen_v[2:0]), .data_be_i(be_v[3*BW-1:0]),
        .data_ID_i(id_v[3*IW-1:0]),
        .data_gnt_o(gnt3_o), .data_req_o(req3_o), .data_wdata_o(wdata3_o),
        .data_wtag_o(wtag3_o), .data_add_o(add3_o), .data_wen_o(wen3_o),
        .data_be_o(be3_o), .data_ID_o(id3_o), .data_gnt_i(gnt3)
    );

    // DUT C: 4 channels, combinational pass-through
    logic [3:0]    req0, gnt0_o;
    logic          gnt0, req0_o, wen0_o;
    logic [DW-1:0] wdata0_o;
    logic [TW-1:0] wtag0_o;
    logic [AW-1:0] add0_o;
    logic [BW-1:0] be0_o;
    logic [IW-1:0] id0_o;

    fanin_req_l2_rr #(.N_CH(4), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .data_req_i(req0), .data_wdata_i(wdata_v), .data_wtag_i(wtag_v),
        .data_add_i(add_v), .data_wen_i(wen_v), .data_be_i(be_v), .data_ID_i(id_v),
        .data_gnt_o(gnt0_o), .data_req_o(req0_o), .data_wdata_o(wdata0_o),
        .data_wtag_o(wtag0_o), .data_add_o(add0_o), .data_wen_o(wen0_o),
        .data_be_o(be0_o), .data_ID_o(id0_o), .data_gnt_i(gnt0)
    );

    int errors = 0;
    int checks = 0;

    // Model of DUT A: pointer, slice valid and scoreboard of queued channels
    int mrr = 0;
    bit mv  = 1'b0;
    int sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_win(input int rr, input logic [3:0] req, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = (rr + k) % n;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One cycle of DUT A: called at a negedge with inputs already driven
    task automatic cycle4(input string tag, input bit use_oh, input logic [3:0] exp_oh);
        int  w;
        bit  ld;
        logic [3:0] oh;
        #1;
        w  = rr_win(mrr, req4, 4);
        ld = (w >= 0) && (!mv || gnt4);
        oh = ld ? (4'b0001 << w) : 4'b0000;
        chk({tag, ".gnt"}, 64'(gnt4_o), 64'(oh));
        if (use_oh) chk({tag, ".gnt_dir"}, 64'(gnt4_o), 64'(exp_oh));
        chk({tag, ".req_o"}, 64'(req4_o), 64'(mv));
        if (mv && sb_q.size() > 0) begin
            chk({tag, ".id"}, 64'(id4_o), 64'(exp_id(sb_q[0])));
            chk({tag, ".addr"}, 64'(add4_o), 64'(exp_addr(sb_q[0])));
            chk({tag, ".wdata"}, wdata4_o, exp_wdata(sb_q[0]));
            chk({tag, ".wtag"}, 64'(wtag4_o), 64'(exp_wtag(sb_q[0])));
            chk({tag, ".be"}, 64'(be4_o), 64'(exp_be(sb_q[0])));
            chk({tag, ".wen"}, 64'(wen4_o), 64'(sb_q[0] % 2));
        end
        @(posedge clk);
        if (mv && gnt4) void'(sb_q.pop_front());
        if (ld) begin
            sb_q.push_back(w);
            mv  = 1'b1;
            mrr = (w + 1) % 4;
        end else if (gnt4) begin
            mv = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rot_oh [6];
        rot_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int c = 0; c < 4; c++) begin
            add_v[c*AW +: AW]   = exp_addr(c);
            id_v[c*IW +: IW]    = exp_id(c);
            wdata_v[c*DW +: DW] = exp_wdata(c);
            wtag_v[c*TW +: TW]  = exp_wtag(c);
            be_v[c*BW +: BW]    = exp_be(c);
            wen_v[c]            = c[0];
        end
        req4 = 4'b0; gnt4 = 1'b0;
        req3 = 3'b0; gnt3 = 1'b0;
        req0 = 4'b0; gnt0 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.req4", 64'(req4_o), 64'd0);
        chk("rst.gnt4", 64'(gnt4_o), 64'd0);
        chk("rst.id4", 64'(id4_o), 64'd0);
        chk("rst.add4", 64'(add4_o), 64'd0);
        chk("rst.wdata4", wdata4_o, 64'd0);
        chk("rst.req3", 64'(req3_o), 64'd0);
        chk("rst.req0", 64'(req0_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin rotation, all requesting, bank always granting
        req4 = 4'b1111; gnt4 = 1'b1;
        for (int i = 0; i < 6; i++) cycle4("rot", 1'b1, rot_oh[i]);

        // Backpressure: ch2 loads, bank stalls for five cycles
        req4 = 4'b1100;
        cycle4("bp.load", 1'b1, 4'b0100);
        gnt4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle4("bp.hold", 1'b1, 4'b0000);
            chk("bp.id_stable", 64'(id4_o), 64'h2A);
        end
        gnt4 = 1'b1;
        cycle4("bp.drain", 1'b1, 4'b1000);

        // Sparse: get pointer to 3, then only ch1 requests
        req4 = 4'b0100;
        cycle4("sp.ch2", 1'b1, 4'b0100);
        req4 = 4'b0010;
        cycle4("sp.ch1", 1'b1, 4'b0010);
        req4 = 4'b0000;
        cycle4("sp.idle", 1'b1, 4'b0000);
        cycle4("sp.empty", 1'b1, 4'b0000);
        req4 = 4'b1111;
        cycle4("sp.hold2", 1'b1, 4'b0100);

        // Mid-transfer reset while the slice is valid
        gnt4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst.req4", 64'(req4_o), 64'd0);
        chk("mrst.id4", 64'(id4_o), 64'd0);
        chk("mrst.add4", 64'(add4_o), 64'd0);
        mv = 1'b0; mrr = 0; sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        req4 = 4'b1010; gnt4 = 1'b1;
        cycle4("mrst.first", 1'b1, 4'b0010);
        cycle4("mrst.next", 1'b1, 4'b1000);
        req4 = 4'b0000;
        cycle4("mrst.drain", 1'b1, 4'b0000);
        gnt4 = 1'b0;

        // Non-power-of-two wrap on the 3-channel instance
        req3 = 3'b100; gnt3 = 1'b1;
        #1 chk("n3.ch2", 64'(gnt3_o), 64'b100);
        @(posedge clk); @(negedge clk);
        req3 = 3'b011;
        #1 chk("n3.wrap_ch0", 64'(gnt3_o), 64'b001);
        chk("n3.id_ch2", 64'(id3_o), 64'h2A);
        @(posedge clk); @(negedge clk);
        #1 chk("n3.ch1", 64'(gnt3_o), 64'b010);
        chk("n3.id_ch0", 64'(id3_o), 64'h28);
        @(posedge clk); @(negedge clk);
        req3 = 3'b000;

        // Combinational instance: same-cycle grant and payload
        req0 = 4'b1001; gnt0 = 1'b0;
        #1 chk("c0.stall_gnt", 64'(gnt0_o), 64'd0);
        chk("c0.stall_req", 64'(req0_o), 64'd1);
        chk("c0.stall_add", 64'(add0_o), 64'(exp_addr(0)));
        @(posedge clk); @(negedge clk);
        gnt0 = 1'b1;
        #1 chk("c0.gnt_ch0", 64'(gnt0_o), 64'b0001);
        chk("c0.add_ch0", 64'(add0_o), 64'(exp_addr(0)));
        chk("c0.id_ch0", 64'(id0_o), 64'(exp_id(0)));
        @(posedge clk); @(negedge clk);
        #1 chk("c0.gnt_ch3", 64'(gnt0_o), 64'b1000);
        chk("c0.add_ch3", 64'(add0_o), 64'(exp_addr(3)));
        @(posedge clk); @(negedge clk);
        req0 = 4'b0000;
        #1 chk("c0.idle_req", 64'(req0_o), 64'd0);
        chk("c0.idle_gnt", 64'(gnt0_o), 64'd0);
        chk("c0.park_add", 64'(add0_o), 64'(exp_addr(0)));
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
